// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM encodings, drain depth,
// register-field width, and the load-use register compare helper.
// Ports: none (package).
package pipeline_ctrl_pkg;

    // Encodings are visible on o_state for debug readback; keep them stable.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_STEP_GO   = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_HALTED    = 3'd5
    } state_t;

    // Advanced cycles after HALT decode until HALT leaves WB (ID->EX->MEM->WB + 1).
    localparam int DRAIN_CYC_DEF = 4;

    localparam int REG_W = 5;

    // Register $zero never carries a real dependency.
    function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the source fields in ID.
// Purely combinational; no state, no backpressure of its own.
// Ports: i_ex_mem_read/i_ex_rt (load in ID/EX), i_id_rs/i_id_rt (ID sources), o_load_use.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    output logic             o_load_use
);

    assign o_load_use = i_ex_mem_read &
                        (reg_match(i_ex_rt, i_id_rs) | reg_match(i_ex_rt, i_id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central 5-stage pipeline sequencer: advance enable, load-use stall/bubble, jump flush,
// run/single-step modes, HALT drain and advanced-cycle counter.
// Latency: o_pipe_en/o_state/o_halted registered (1 cycle after trigger); stall/bubble/flush combinational.
// Ports: clk, rst (async active-low); debug i_start/i_step_mode/i_step; ID/EX hazard inputs;
//        stall/bubble/flush controls, o_state, o_halted, o_cycle_cnt.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_step_mode,
    input  logic             i_step,
    input  logic             i_halt,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_ex_MemRead,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic             i_jump_taken,
    output logic             o_pipe_en,
    output logic             o_pc_stall,
    output logic             o_if_id_stall,
    output logic             o_id_ex_bubble,
    output logic             o_flush,
    output logic [2:0]       o_state,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_cycle_cnt
);

    localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

    state_t               r_state;
    logic                 r_pipe_en;
    logic                 r_halted;
    logic                 r_step_mode;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic [CNT_W-1:0]     r_cycle_cnt;

    state_t               w_state_nx;
    logic                 w_pipe_en_nx;
    logic                 w_step_mode_nx;
    logic [DRAIN_W-1:0]   w_drain_nx;
    logic                 w_cnt_clr;
    logic                 w_load_use;
    logic                 w_lu_stall;
    logic                 w_halt_acc;
    logic                 w_in_drain;

    hazard_detect u_hazard (
        .i_ex_mem_read (i_ex_MemRead),
        .i_ex_rt       (i_ex_rt),
        .i_id_rs       (i_id_rs),
        .i_id_rt       (i_id_rt),
        .o_load_use    (w_load_use)
    );

    // A taken jump squashes both the load-use stall and any wrong-path HALT.
    // HALT under a load-use stall is not accepted; it re-presents next cycle.
    assign w_lu_stall = r_pipe_en & ~i_jump_taken & w_load_use;
    assign w_halt_acc = r_pipe_en & i_halt & ~i_jump_taken & ~w_load_use;
    assign w_in_drain = (r_state == ST_DRAIN);

    always_comb begin
        w_state_nx     = r_state;
        w_step_mode_nx = r_step_mode;
        w_drain_nx     = r_drain_cnt;
        w_cnt_clr      = 1'b0;
        w_pipe_en_nx   = 1'b0;

        unique case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (i_start) begin
                    w_cnt_clr      = 1'b1;
                    w_step_mode_nx = i_step_mode;
                    w_state_nx     = i_step_mode ? ST_STEP_WAIT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_halt_acc) begin
                    w_state_nx = ST_DRAIN;
                    w_drain_nx = DRAIN_W'(DRAIN_CYC);
                end
            end
            ST_STEP_WAIT: begin
                if (i_step) w_state_nx = ST_STEP_GO;
            end
            ST_STEP_GO: begin
                if (w_halt_acc) begin
                    w_state_nx = ST_DRAIN;
                    w_drain_nx = DRAIN_W'(DRAIN_CYC);
                end else begin
                    w_state_nx = ST_STEP_WAIT;
                end
            end
            ST_DRAIN: begin
                // Only advancing cycles move HALT down the pipe.
                if (r_pipe_en) begin
                    w_drain_nx = r_drain_cnt - DRAIN_W'(1);
                    if (r_drain_cnt == DRAIN_W'(1)) w_state_nx = ST_HALTED;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase

        // Advance enable for the cycle the next state is visible.
        unique case (w_state_nx)
            ST_RUN, ST_STEP_GO: w_pipe_en_nx = 1'b1;
            ST_DRAIN:           w_pipe_en_nx = ~r_step_mode | (w_in_drain & i_step);
            default:            w_pipe_en_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_pipe_en   <= 1'b0;
            r_halted    <= 1'b0;
            r_step_mode <= 1'b0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_pipe_en   <= w_pipe_en_nx;
            r_halted    <= (w_state_nx == ST_HALTED);
            r_step_mode <= w_step_mode_nx;
            r_drain_cnt <= w_drain_nx;
        end
    end

    // Saturating count of advanced cycles since the last start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cycle_cnt <= '0;
        end else if (r_pipe_en && !(&r_cycle_cnt)) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

    // Fetch is frozen for the whole drain, advancing or not.
    assign o_pipe_en      = r_pipe_en;
    assign o_pc_stall     = w_lu_stall | w_in_drain;
    assign o_if_id_stall  = w_lu_stall | w_in_drain;
    assign o_id_ex_bubble = w_lu_stall;
    assign o_flush        = r_pipe_en & i_jump_taken;
    assign o_state        = r_state;
    assign o_halted       = r_halted;
    assign o_cycle_cnt    = r_cycle_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic       clk;
    logic       rst;
    logic       start, step_mode, step, halt, mem_read, jump;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       s1_start, s1_halt;

    logic        pe0, pcs0, ifs0, bub0, fl0, hl0;
    logic [2:0]  st0;
    logic [31:0] cnt0;
    logic        pe1, pcs1, ifs1, bub1, fl1, hl1;
    logic [2:0]  st1;
    logic [3:0]  cnt1;

    typedef struct {
        string      tag;
        logic [8:0] outs;
        int         cnt;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    pipeline_ctrl #(.DRAIN_CYC(4), .CNT_W(32)) u0 (
        .clk(clk), .rst(rst), .i_start(start), .i_step_mode(step_mode), .i_step(step),
        .i_halt(halt), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_ex_MemRead(mem_read),
        .i_ex_rt(ex_rt), .i_jump_taken(jump),
        .o_pipe_en(pe0), .o_pc_stall(pcs0), .o_if_id_stall(ifs0), .o_id_ex_bubble(bub0),
        .o_flush(fl0), .o_state(st0), .o_halted(hl0), .o_cycle_cnt(cnt0)
    );

    pipeline_ctrl #(.DRAIN_CYC(4), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .i_start(s1_start), .i_step_mode(1'b0), .i_step(1'b0),
        .i_halt(s1_halt), .i_id_rs(5'd0), .i_id_rt(5'd0), .i_ex_MemRead(1'b0),
        .i_ex_rt(5'd0), .i_jump_taken(1'b0),
        .o_pipe_en(pe1), .o_pc_stall(pcs1), .o_if_id_stall(ifs1), .o_id_ex_bubble(bub1),
        .o_flush(fl1), .o_state(st1), .o_halted(hl1), .o_cycle_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pipe_en, pc_stall, if_id_stall, bubble, flush, state[2:0], halted}
    function automatic logic [8:0] mk(input logic pe, input logic pcs, input logic ifs,
                                      input logic bub, input logic fl, input logic [2:0] st,
                                      input logic hl);
        return {pe, pcs, ifs, bub, fl, st, hl};
    endfunction

    // Called 1 time unit after a rising edge with inputs already driven for this cycle.
    task automatic cyc(input string tag, input int sel, input logic [8:0] eo, input int ec);
        exp_t        e;
        logic [8:0]  obs_o;
        logic [31:0] obs_c;
        e.tag = tag; e.outs = eo; e.cnt = ec;
        q.push_back(e);
        #1;
        e = q.pop_front();
        if (sel == 0) begin
            obs_o = {pe0, pcs0, ifs0, bub0, fl0, st0, hl0};
            obs_c = cnt0;
        end else begin
            obs_o = {pe1, pcs1, ifs1, bub1, fl1, st1, hl1};
            obs_c = {28'd0, cnt1};
        end
        n_vec++;
        assert (obs_o === e.outs) else begin
            n_fail++;
            $error("FAIL %s outs: observed %b required %b", e.tag, obs_o, e.outs);
        end
        n_vec++;
        assert (obs_c === 32'(e.cnt)) else begin
            n_fail++;
            $error("FAIL %s cnt: observed %0d required %0d", e.tag, obs_c, e.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [8:0] IDLE_O = 9'b0_0000_000_0;

    initial begin
        rst = 1'b0; start = 0; step_mode = 0; step = 0; halt = 0; mem_read = 0; jump = 0;
        id_rs = 0; id_rt = 0; ex_rt = 0; s1_start = 0; s1_halt = 0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 0, IDLE_O, 0);
        rst = 1'b1;
        cyc("idle", 0, IDLE_O, 0);

        // Continuous run, HALT on the 10th advanced cycle, 4-cycle drain.
        start = 1; step_mode = 0;
        cyc("start_run", 0, IDLE_O, 0);
        start = 0;
        for (int k = 1; k <= 10; k++) begin
            halt = (k == 10);
            cyc("run", 0, mk(1,0,0,0,0,3'd1,0), k - 1);
        end
        halt = 0;
        for (int d = 1; d <= 4; d++) cyc("drain", 0, mk(1,1,1,0,0,3'd4,0), 9 + d);
        cyc("halted", 0, mk(0,0,0,0,0,3'd5,1), 14);
        cyc("halted_hold", 0, mk(0,0,0,0,0,3'd5,1), 14);

        // Restart from HALTED; load-use patterns in RUN.
        start = 1;
        cyc("restart", 0, mk(0,0,0,0,0,3'd5,1), 14);
        start = 0;
        mem_read = 1; ex_rt = 8; id_rs = 8;
        cyc("lu_rs", 0, mk(1,1,1,1,0,3'd1,0), 0);
        ex_rt = 0; id_rs = 0;
        cyc("lu_r0", 0, mk(1,0,0,0,0,3'd1,0), 1);
        ex_rt = 5; id_rt = 5; id_rs = 8;
        cyc("lu_rt", 0, mk(1,1,1,1,0,3'd1,0), 2);
        id_rt = 9;
        cyc("lu_miss", 0, mk(1,0,0,0,0,3'd1,0), 3);
        mem_read = 0; id_rt = 5;
        cyc("lu_noload", 0, mk(1,0,0,0,0,3'd1,0), 4);
        mem_read = 1; jump = 1; halt = 1;
        cyc("flush_wins", 0, mk(1,0,0,0,1,3'd1,0), 5);
        mem_read = 0; jump = 0; halt = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
        for (int k = 6; k <= 56; k++) cyc("run_to57", 0, mk(1,0,0,0,0,3'd1,0), k);

        // Asynchronous reset mid-RUN with count at 57 and live hazard inputs.
        rst = 0; mem_read = 1; ex_rt = 8; id_rs = 8; jump = 1;
        cyc("rst_mid_run", 0, IDLE_O, 0);
        rst = 1; mem_read = 0; ex_rt = 0; id_rs = 0; jump = 0;
        cyc("post_rst", 0, IDLE_O, 0);

        // HALT under load-use stall is deferred one cycle.
        start = 1; step_mode = 0;
        cyc("start2", 0, IDLE_O, 0);
        start = 0; mem_read = 1; ex_rt = 8; id_rs = 8; halt = 1;
        cyc("halt_lu", 0, mk(1,1,1,1,0,3'd1,0), 0);
        mem_read = 0;
        cyc("halt_again", 0, mk(1,0,0,0,0,3'd1,0), 1);
        halt = 0; ex_rt = 0; id_rs = 0;
        for (int d = 0; d < 4; d++) cyc("drain2", 0, mk(1,1,1,0,0,3'd4,0), 2 + d);
        cyc("halted2", 0, mk(0,0,0,0,0,3'd5,1), 6);

        // Single-step mode: three pulses five cycles apart.
        start = 1; step_mode = 1;
        cyc("start_step", 0, mk(0,0,0,0,0,3'd5,1), 6);
        start = 0; step_mode = 0;
        cyc("step_wait0", 0, mk(0,0,0,0,0,3'd2,0), 0);
        for (int p = 0; p < 3; p++) begin
            step = 1;
            cyc("step_pulse", 0, mk(0,0,0,0,0,3'd2,0), p);
            step = 0;
            cyc("step_go", 0, mk(1,0,0,0,0,3'd3,0), p);
            for (int w = 0; w < 3; w++) cyc("step_wait", 0, mk(0,0,0,0,0,3'd2,0), p + 1);
        end

        // HALT during a step, then drain advances only on step pulses.
        step = 1;
        cyc("step_pulse4", 0, mk(0,0,0,0,0,3'd2,0), 3);
        step = 0; halt = 1;
        cyc("step_go_halt", 0, mk(1,0,0,0,0,3'd3,0), 3);
        halt = 0;
        cyc("sdrain_idle", 0, mk(0,1,1,0,0,3'd4,0), 4);
        for (int d = 0; d < 4; d++) begin
            step = 1;
            cyc("sdrain_pulse", 0, mk(0,1,1,0,0,3'd4,0), 4 + d);
            step = 0;
            cyc("sdrain_adv", 0, mk(1,1,1,0,0,3'd4,0), 4 + d);
            if (d < 3) cyc("sdrain_wait", 0, mk(0,1,1,0,0,3'd4,0), 5 + d);
            else       cyc("sdrain_halted", 0, mk(0,0,0,0,0,3'd5,1), 8);
        end

        // 4-bit counter saturation; start ignored while running.
        s1_start = 1;
        cyc("c4_start", 1, IDLE_O, 0);
        for (int k = 1; k <= 20; k++) begin
            s1_start = (k == 5);
            s1_halt  = (k == 20);
            cyc("c4_run", 1, mk(1,0,0,0,0,3'd1,0), (k - 1 > 15) ? 15 : k - 1);
        end
        s1_start = 0; s1_halt = 0;
        for (int d = 0; d < 4; d++) cyc("c4_drain", 1, mk(1,1,1,0,0,3'd4,0), 15);
        s1_start = 1;
        cyc("c4_halted", 1, mk(0,0,0,0,0,3'd5,1), 15);
        s1_start = 0;
        cyc("c4_restart", 1, mk(1,0,0,0,0,3'd1,0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
